add_sub_arbiter: RTL



---
 rtl/add_sub_arbiter_pkg.sv | 9 +
 rtl/add_sub_arbiter_rr_arb2.sv | 13 +
 rtl/add_sub_arbiter.sv | 91 +++++++++
 3 files changed

// File: rtl/add_sub_arbiter_pkg.sv
// add_sub_arbiter_pkg: shared word width, opcode and FSM state encodings for the add/sub arbiter
package add_sub_arbiter_pkg;
  localparam int WORD_W = 20;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
endpackage

// File: rtl/add_sub_arbiter_rr_arb2.sv
// rr_arb2: 2-way round-robin grant; on contention the requester that is not last_grant wins
module rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic grant0,
  output logic grant1
);
  always_comb begin
    grant0 = valid0 & (~valid1 | last_grant);
    grant1 = valid1 & (~valid0 | ~last_grant);
  end
endmodule

// File: rtl/add_sub_arbiter.sv
// add_sub_arbiter: two requesters share one add/sub datapath via round-robin and an IDLE/EXEC/RESP FSM
// Optional per-requester handshake counters when ADD_SUB_ARB_STATS_EN is defined.
module add_sub_arbiter
  import add_sub_arbiter_pkg::*;
#(
  parameter int WIDTH = WORD_W
`ifdef ADD_SUB_ARB_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic             req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic             req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_cout
`ifdef ADD_SUB_ARB_STATS_EN
  , output logic [CNT_W-1:0] ops0_cnt
  , output logic [CNT_W-1:0] ops1_cnt
`endif
);
  logic [1:0] state;
  logic last_grant, grant0, grant1, op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH:0] sum;
  rr_arb2 u_arb (
    .valid0(req0_valid),
    .valid1(req1_valid),
    .last_grant(last_grant),
    .grant0(grant0),
    .grant1(grant1)
  );
  // rst_n gating keeps ready low while reset is held even though state is already IDLE
  always_comb begin
    req0_ready = rst_n & (state == ST_IDLE) & grant0;
    req1_ready = rst_n & (state == ST_IDLE) & grant1;
    sum = {1'b0, a_q} + {1'b0, (op_q == OP_ADD) ? b_q : ~b_q} + {{WIDTH{1'b0}}, op_q == OP_SUB};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      last_grant <= 1'b1;
      op_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      rsp_valid <= 1'b0;
      rsp_id <= 1'b0;
      rsp_data <= '0;
      rsp_cout <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (req0_ready | req1_ready) begin
        state <= ST_EXEC;
        last_grant <= req1_ready;
        op_q <= req1_ready ? req1_op : req0_op;
        a_q <= req1_ready ? req1_a : req0_a;
        b_q <= req1_ready ? req1_b : req0_b;
      end
    end else if (state == ST_EXEC) begin
      state <= ST_RESP;
      rsp_valid <= 1'b1;
      rsp_id <= last_grant;
      rsp_data <= sum[WIDTH-1:0];
      rsp_cout <= sum[WIDTH];
    end else if (rsp_ready) begin
      state <= ST_IDLE;
      rsp_valid <= 1'b0;
    end
  end
`ifdef ADD_SUB_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops0_cnt <= '0;
      ops1_cnt <= '0;
    end else begin
      ops0_cnt <= ops0_cnt + CNT_W'(req0_ready & req0_valid);
      ops1_cnt <= ops1_cnt + CNT_W'(req1_ready & req1_valid);
    end
  end
`endif
endmodule
